dmem_lsu: RTL and testbench

//  Parametrised data memory with load/store unit front end: byte/half/word accesses, byte-lane writes,

---
 rtl/dmem_lsu_pkg.sv | 50 +++++
 rtl/dmem_lsu_ram.sv | 30 +++
 rtl/dmem_lsu.sv | 137 +++++++++++++
 tb/tb_dmem_lsu.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg: shared encodings and helper functions for the data-memory LSU.
// Access sizes, FSM state type, byte-enable generation, store-data replication
// and load lane-select/extension live here so the top and RAM agree on them.
package dmem_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Byte lanes touched by an access of the given size at the given low address bits.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << lane;
      SZ_HALF: byte_en = 4'b0011 << {lane[1], 1'b0};
      SZ_WORD: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  // Right-aligned store data copied onto every lane; byte enables pick the live copy.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: store_data = {4{wdata[7:0]}};
      SZ_HALF: store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  endfunction

  // Select the addressed byte/half from a RAM word and sign- or zero-extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: load_extract = {{24{~uns & b[7]}}, b};
      SZ_HALF: load_extract = {{16{~uns & h[15]}}, h};
      default: load_extract = word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_ram.sv
// dmem_lsu_ram: DEPTH x 32 synchronous RAM with four byte write enables and a
// registered read port. INIT_FILE is carried for interface compatibility.
module dmem_lsu_ram #(
  parameter int DEPTH     = 256,
  parameter     INIT_FILE = "",
  parameter int IDX_W     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [3:0]       we,
  input  logic             re,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  // Byte-lane writes and registered read; read data holds until the next read.
  // NOTE: storage and its read register have no reset -- contents must survive reset and RAM macros lack one.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
    end
    if (re) rdata_q <= mem[idx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: data memory with load/store front end. Byte/half/word accesses,
// sign/zero extension, READ_LAT-cycle loads, valid/ready request and response.
// Optional feature: define DMEM_LSU_ALIGN_CHK_EN to flag misaligned half/word accesses.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int READ_LAT  = 1,
  parameter     INIT_FILE = "DMEM_mem.bin",
  parameter int ADDR_W    = $clog2(DEPTH) + 2
) (
  input  logic              LSU_clk,
  input  logic              LSU_rst_n,
  input  logic              LSU_req_valid,
  output logic              LSU_req_ready,
  input  logic              LSU_req_write,
  input  logic [1:0]        LSU_req_size,
  input  logic              LSU_req_unsigned,
  input  logic [ADDR_W-1:0] LSU_req_addr,
  input  logic [31:0]       LSU_req_wdata,
  output logic              LSU_resp_valid,
  input  logic              LSU_resp_ready,
  output logic [31:0]       LSU_resp_rdata,
  output logic              LSU_resp_err
);

  localparam int CNT_W = 4;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         lane_q, lane_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic               load_q, load_d;
  logic               err_q, err_d;

  logic               accept;
  logic               req_err;
  logic               req_load;
  logic [3:0]         ram_we;
  logic               ram_re;
  logic [31:0]        ram_rdata;

  // Request decode: acceptance, error classification and RAM strobes.
  // NOTE: combinational blocks use blocking '=' and give every output a default first, so no latch is inferred.
  always_comb begin
    accept  = LSU_req_valid && (state_q == ST_IDLE);
    req_err = (LSU_req_size == SZ_RSVD);
`ifdef DMEM_LSU_ALIGN_CHK_EN
    if ((LSU_req_size == SZ_HALF && LSU_req_addr[0]) ||
        (LSU_req_size == SZ_WORD && LSU_req_addr[1:0] != 2'b00)) req_err = 1'b1;
`endif
    req_load = !LSU_req_write && !req_err;
    ram_we   = (accept && LSU_req_write && !req_err) ? byte_en(LSU_req_size, LSU_req_addr[1:0]) : 4'b0000;
    ram_re   = accept && req_load;
  end

  dmem_lsu_ram #(
    .DEPTH    (DEPTH),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk  (LSU_clk),
    .we   (ram_we),
    .re   (ram_re),
    .idx  (LSU_req_addr[ADDR_W-1:2]),
    .wdata(store_data(LSU_req_size, LSU_req_wdata)),
    .rdata(ram_rdata)
  );

  // Next-state logic: capture the access on accept, count read latency, hold response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    size_d  = size_q;
    uns_d   = uns_q;
    load_d  = load_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          lane_d = LSU_req_addr[1:0];
          size_d = LSU_req_size;
          uns_d  = LSU_req_unsigned;
          load_d = req_load;
          err_d  = req_err;
          if (req_load && READ_LAT > 1) begin
            state_d = ST_BUSY;
            cnt_d   = CNT_W'(READ_LAT - 1);
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q == CNT_W'(1)) state_d = ST_RESP;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_RESP: begin
        if (LSU_resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; asynchronous reset discards any pending load or response.
  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge LSU_clk or negedge LSU_rst_n) begin
    if (!LSU_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lane_q  <= '0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  // Outputs: response fields are zero outside RESP; RAM read data is stable while held.
  always_comb begin
    LSU_req_ready  = (state_q == ST_IDLE);
    LSU_resp_valid = (state_q == ST_RESP);
    LSU_resp_err   = (state_q == ST_RESP) && err_q;
    LSU_resp_rdata = ((state_q == ST_RESP) && load_q) ?
                     load_extract(ram_rdata, size_q, lane_q, uns_q) : 32'h0;
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: self-checking bench for dmem_lsu. Two instances (READ_LAT 1 and 4)
// share request wires; sel routes valid/ready to one. A byte-level memory model
// predicts every response; directed cases pin the model with literal values.
module tb_dmem_lsu;

  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH) + 2;

  logic          clk;
  logic          rst_n;
  bit            sel;
  logic          req_valid, req_write, req_unsigned, resp_ready;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;

  logic          rdy0, rdy1, rv0, rv1, err0, err1;
  logic [31:0]   rd0, rd1;

  logic          req_ready, resp_valid, resp_err;
  logic [31:0]   resp_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_m [2][DEPTH];

  dmem_lsu #(.DEPTH(DEPTH), .READ_LAT(1), .INIT_FILE("")) u_dut0 (
    .LSU_clk(clk), .LSU_rst_n(rst_n),
    .LSU_req_valid(req_valid & ~sel), .LSU_req_ready(rdy0),
    .LSU_req_write(req_write), .LSU_req_size(req_size), .LSU_req_unsigned(req_unsigned),
    .LSU_req_addr(req_addr), .LSU_req_wdata(req_wdata),
    .LSU_resp_valid(rv0), .LSU_resp_ready(resp_ready & ~sel),
    .LSU_resp_rdata(rd0), .LSU_resp_err(err0)
  );

  dmem_lsu #(.DEPTH(DEPTH), .READ_LAT(4), .INIT_FILE("")) u_dut1 (
    .LSU_clk(clk), .LSU_rst_n(rst_n),
    .LSU_req_valid(req_valid & sel), .LSU_req_ready(rdy1),
    .LSU_req_write(req_write), .LSU_req_size(req_size), .LSU_req_unsigned(req_unsigned),
    .LSU_req_addr(req_addr), .LSU_req_wdata(req_wdata),
    .LSU_resp_valid(rv1), .LSU_resp_ready(resp_ready & sel),
    .LSU_resp_rdata(rd1), .LSU_resp_err(err1)
  );

  assign req_ready  = sel ? rdy1 : rdy0;
  assign resp_valid = sel ? rv1  : rv0;
  assign resp_rdata = sel ? rd1  : rd0;
  assign resp_err   = sel ? err1 : err0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit, got=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h required=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural model: byte-granular memory, applies the access and returns the expected response.
  function automatic void model_xact(input bit d, input logic w, input logic [1:0] sz, input logic u,
                                     input logic [AW-1:0] a, input logic [31:0] wd,
                                     output logic [31:0] er, output logic ee);
    int idx, start, n;
    logic [31:0] word;
    idx = int'(a[AW-1:2]);
    er  = 32'h0;
    ee  = (sz == 2'd3);
`ifdef DMEM_LSU_ALIGN_CHK_EN
    if ((sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)) ee = 1'b1;
`endif
    if (ee) return;
    n     = 1 << sz;
    start = (sz == 2'd0) ? int'(a[1:0]) : (sz == 2'd1) ? (a[1] ? 2 : 0) : 0;
    if (w) begin
      for (int k = 0; k < n; k++) mem_m[d][idx][(start+k)*8 +: 8] = wd[k*8 +: 8];
    end else begin
      word = mem_m[d][idx];
      for (int k = 0; k < n; k++) er[k*8 +: 8] = word[(start+k)*8 +: 8];
      if (!u && er[n*8-1]) begin
        for (int k = n*8; k < 32; k++) er[k] = 1'b1;
      end
    end
  endfunction

  task automatic randomize_req_fields();
    req_write    = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = AW'($urandom);
    req_wdata    = $urandom;
  endtask

  // One transaction: issue, wait (bounded), check latency/data/err against the model,
  // hold resp_ready low for 'hold' cycles with a competing request, then retire.
  task automatic xact(input bit d, input logic w, input logic [1:0] sz, input logic u,
                      input logic [AW-1:0] a, input logic [31:0] wd, input int hold,
                      output logic [31:0] got_r, output logic got_e);
    logic [31:0] er;
    logic        ee;
    int          lat, exp_lat;
    bit          seen;
    model_xact(d, w, sz, u, a, wd, er, ee);
    exp_lat = (w || ee) ? 1 : (d ? 4 : 1);
    got_r = 32'h0;
    got_e = 1'b0;
    @(negedge clk);
    sel = d;
    req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    #1;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    randomize_req_fields();
    lat  = 0;
    seen = 0;
    while (!seen && lat < 16) begin
      @(negedge clk);
      lat++;
      if (resp_valid) seen = 1;
      else check("req_ready_low_wait", 32'(req_ready), 32'd0);
    end
    check("resp_seen", 32'(seen), 32'd1);
    if (!seen) return;
    check("latency", 32'(lat), 32'(exp_lat));
    check("rdata", resp_rdata, er);
    check("err", 32'(resp_err), 32'(ee));
    got_r = resp_rdata;
    got_e = resp_err;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      randomize_req_fields();
      @(negedge clk);
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, got_r);
      check("hold_err", 32'(resp_err), 32'(got_e));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check("valid_drop", 32'(resp_valid), 32'd0);
    check("ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    logic        e;

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++) mem_m[d][i] = 32'h0;

    sel = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    randomize_req_fields();
    rst_n = 1'b0;
    #2;
    check("rst_valid0", 32'(rv0), 32'd0);
    check("rst_rdata0", rd0, 32'h0);
    check("rst_err0", 32'(err0), 32'd0);
    check("rst_ready0", 32'(rdy0), 32'd1);
    check("rst_valid1", 32'(rv1), 32'd0);
    check("rst_ready1", 32'(rdy1), 32'd1);
    #18 rst_n = 1'b1;

    // Define every word in both memories so the model knows all contents.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++)
        xact(1'(d), 1'b1, 2'd2, 1'b0, AW'(i*4), $urandom, 0, r, e);

    // sw/lw round trip.
    xact(0, 1'b1, 2'd2, 1'b0, AW'('h10), 32'hDEADBEEF, 0, r, e);
    xact(0, 1'b0, 2'd2, 1'b0, AW'('h10), 32'h0, 0, r, e);
    check("t1_lw", r, 32'hDEADBEEF);
    check("t1_err", 32'(e), 32'd0);

    // sb lane 1 with sign/zero extension; neighbours untouched.
    xact(0, 1'b1, 2'd2, 1'b0, AW'('h20), 32'h11223344, 0, r, e);
    xact(0, 1'b1, 2'd0, 1'b0, AW'('h21), 32'hABCD5580, 0, r, e);
    xact(0, 1'b0, 2'd0, 1'b0, AW'('h21), 32'h0, 0, r, e);
    check("t2_lb", r, 32'hFFFFFF80);
    xact(0, 1'b0, 2'd0, 1'b1, AW'('h21), 32'h0, 0, r, e);
    check("t2_lbu", r, 32'h00000080);
    xact(0, 1'b0, 2'd2, 1'b0, AW'('h20), 32'h0, 0, r, e);
    check("t2_lw", r, 32'h11228044);

    // sh upper half; READ_LAT=4 instance checks latency inside xact.
    for (int d = 0; d < 2; d++) begin
      xact(1'(d), 1'b1, 2'd1, 1'b0, AW'('h32), 32'h12348001, 0, r, e);
      xact(1'(d), 1'b0, 2'd1, 1'b0, AW'('h32), 32'h0, 0, r, e);
      check("t3_lh", r, 32'hFFFF8001);
      xact(1'(d), 1'b0, 2'd1, 1'b1, AW'('h32), 32'h0, 0, r, e);
      check("t3_lhu", r, 32'h00008001);
    end

    // Response held for 5 cycles with a competing request.
    xact(0, 1'b0, 2'd2, 1'b0, AW'('h10), 32'h0, 5, r, e);
    check("t4_lw_held", r, 32'hDEADBEEF);

    // Reserved size store leaves RAM alone; misaligned word load.
    xact(0, 1'b1, 2'd2, 1'b0, AW'('h40), 32'hCAFEF00D, 0, r, e);
    xact(0, 1'b1, 2'd3, 1'b0, AW'('h40), 32'hFFFFFFFF, 0, r, e);
    check("t5_rsvd_err", 32'(e), 32'd1);
    check("t5_rsvd_rdata", r, 32'h0);
    xact(0, 1'b0, 2'd2, 1'b0, AW'('h40), 32'h0, 0, r, e);
    check("t5_unchanged", r, 32'hCAFEF00D);
    xact(0, 1'b0, 2'd2, 1'b0, AW'('h13), 32'h0, 0, r, e);
`ifdef DMEM_LSU_ALIGN_CHK_EN
    check("t5_mis_err", 32'(e), 32'd1);
    check("t5_mis_rdata", r, 32'h0);
`else
    check("t5_mis_err", 32'(e), 32'd0);
    check("t5_mis_rdata", r, 32'hDEADBEEF);
`endif

    // Reset during BUSY on the READ_LAT=4 instance.
    xact(1, 1'b1, 2'd2, 1'b0, AW'('h50), 32'h5A5AA5A5, 0, r, e);
    @(negedge clk);
    sel = 1'b1;
    req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = AW'('h50);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t6_busy_valid", 32'(resp_valid), 32'd0);
    check("t6_busy_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(resp_valid), 32'd0);
    check("t6_rst_rdata", resp_rdata, 32'h0);
    check("t6_rst_err", 32'(resp_err), 32'd0);
    check("t6_rst_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_idle_valid", 32'(resp_valid), 32'd0);
    check("t6_idle_ready", 32'(req_ready), 32'd1);
    xact(1, 1'b0, 2'd2, 1'b0, AW'('h50), 32'h0, 0, r, e);
    check("t6_store_kept", r, 32'h5A5AA5A5);

    // Randomized traffic on both instances against the model.
    for (int i = 0; i < 300; i++) begin
      xact(1'($urandom), 1'($urandom), 2'($urandom_range(0, 7) == 0 ? 3 : $urandom_range(0, 2)),
           1'($urandom), AW'($urandom), $urandom, int'($urandom_range(0, 3)), r, e);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
